tv80_alu16_seq: RTL
===================

// Module: tv80_alu16_seq
// PURPOSE
//  Initiator side of the tv80 8-bit ALU interface: sequences 16-bit ADD/ADC/SBC (HL,ss) through the 8-bit ALU.
//  Issues the low-byte op, then the high-byte op, and returns the 16-bit result and final flags over a valid/ready pair.
//  The ALU is instantiated beside this block; its Q/F_Out return combinationally in the issue cycle.
// PARAMETERS
//  ALU_ADD  4'b0000  ALU_Op code driven for an add with no carry-in.
//  ALU_ADC  4'b0001  ALU_Op code driven for an add with carry-in.
//  ALU_SBC  4'b0011  ALU_Op code driven for a subtract with borrow-in.
// PORTS
//  clk          in   1   single clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when valid&ready
//  req_op       in   2   00 ADD16, 01 ADC16, 10 SBC16, 11 reserved
//  req_a        in   16  operand A (HL)
//  req_b        in   16  operand B (ss)
//  req_f        in   8   incoming F register
//  rsp_valid    out  1   result present
//  rsp_ready    in   1   result consumed when valid&ready
//  rsp_res      out  16  16-bit result
//  rsp_f        out  8   resulting F register
//  alu_op       out  4   to ALU ALU_Op
//  alu_busa     out  8   to ALU BusA
//  alu_busb     out  8   to ALU BusB
//  alu_f_in     out  8   to ALU F_In
//  alu_arith16  out  1   to ALU Arith16
//  alu_z16      out  1   to ALU Z16
//  alu_ir       out  6   to ALU IR, constant 0
//  alu_iset     out  2   to ALU ISet, constant 0
//  alu_q        in   8   from ALU Q
//  alu_f_out    in   8   from ALU F_Out
// BEHAVIOUR
//  Reset (async on reset_n low): state IDLE; rsp_valid=0; rsp_res=0; rsp_f=0; internal operand and flag registers=0.
//  req_ready = (state==IDLE); it reads 1 on the first cycle after reset release.
//  FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
//   IDLE: on valid&ready, latch op, a, b and f; go to LO.
//   LO:   drive the low bytes and latched f; register alu_q as res_lo and alu_f_out as f_lo; go to HI.
//   HI:   drive the high bytes with alu_f_in=f_lo; register {alu_q,res_lo} and alu_f_out; assert rsp_valid; go to DONE.
//   DONE: hold rsp_* stable until rsp_ready; on handshake, drop rsp_valid and go to IDLE.
//  Latency: accept at cycle N, rsp_valid at N+3. Peak throughput is one op per 4 cycles.
//  The next request is accepted no earlier than the cycle after the response handshake.
//  Op mapping (low op / high op / arith16 / z16):
//   ADD16: ADD / ADC / 1 / 0. Arith16 keeps S, Z and P from req_f; H comes from bit 11; C from bit 15; N=0.
//   ADC16: ADC / ADC / 0 / high byte only.
//   SBC16: SBC / SBC / 0 / high byte only.
//   For ADC16 and SBC16, Z=1 only if both bytes are zero: the high pass keeps the low pass Z when the high Q is zero.
//   Reserved op 11 executes exactly as ADD16.
//  S, V, H, C, X and Y in rsp_f come from the high pass; N comes from the op.
//  In IDLE and DONE: alu_op=ALU_ADD; alu_busa, alu_busb, alu_f_in, arith16 and z16 all 0.
//  Reset mid-operation aborts the op; no response is produced; the FSM restarts in IDLE.
//  rsp_ready high while rsp_valid is low has no effect.
//  req_valid while busy is ignored; the request is not latched.
// STRUCTURE
//  Shared package tv80_pkg holds: state enum (IDLE/LO/HI/DONE), req_op encodings, flag bit indices (C0 N1 P2 X3 H4 Y5 Z6 S7).
//  Single module, no sub-module. The ALU is an external sibling instance wired at the parent level.
//  The bench instantiates the real ALU as the responder.
// TESTING
//  1. ADD16 a=0x1234 b=0x0FCD f=0xC4 -> res=0x2201 f=0xF4 (S/Z/P kept, H=1, Y=1, C=0); rsp_valid 3 cycles after accept.
//  2. ADC16 a=0xFFFF b=0x0000 f=0x01 -> res=0x0000 f=0x51 (Z, H and C set; V=0).
//  3. SBC16 a=0x8000 b=0x0001 f=0x00 -> res=0x7FFF f=0x3E (V, N, H, X and Y set; C=0).
//  4. SBC16 a=0x0100 b=0x0001 f=0x00 -> res=0x00FF with Z=0 (zero high byte must not set Z).
//  5. Hold rsp_ready=0 for 5 cycles -> rsp_res and rsp_f stable and req_ready=0; a queued req is accepted the cycle after the handshake.
//  6. Drop reset_n in HI -> rsp_valid=0 immediately; req_ready=1 after release; no stale response ever appears.

Source files
------------

// File: rtl/tv80_pkg.sv
// Shared definitions for the tv80 16-bit ALU sequencer: FSM states,
// request op encodings and F register bit positions.
package tv80_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // req_op encodings
    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_ADC16 = 2'b01;
    localparam logic [1:0] OP_SBC16 = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // F register bit indices
    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_X = 3;
    localparam int FLAG_H = 4;
    localparam int FLAG_Y = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;

    // The reserved encoding runs as ADD16, so anything that is not ADC/SBC is an add.
    function automatic logic is_add16(input logic [1:0] op);
        return (op != OP_ADC16) && (op != OP_SBC16);
    endfunction

endpackage

// File: rtl/tv80_alu16_seq.sv
// Drives a 16-bit ADD/ADC/SBC through the tv80 8-bit ALU as two byte passes
// (low then high) and returns the combined result over a valid/ready pair.
module tv80_alu16_seq
    import tv80_pkg::*;
#(
    parameter logic [3:0] ALU_ADD = 4'b0000,
    parameter logic [3:0] ALU_ADC = 4'b0001,
    parameter logic [3:0] ALU_SBC = 4'b0011
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  req_f,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_res,
    output logic [7:0]  rsp_f,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [5:0]  alu_ir,
    output logic [1:0]  alu_iset,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out
);

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q;
    logic [15:0] a_q, b_q;
    logic [7:0]  f_q;
    logic [7:0]  res_lo_q;
    logic [7:0]  f_lo_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_res_q;
    logic [7:0]  rsp_f_q;
    logic        add16;

    assign add16     = is_add16(op_q);
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_f     = rsp_f_q;
    assign alu_ir    = 6'd0;
    assign alu_iset  = 2'd0;

    // Next state: one cycle per byte pass, then wait for the response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU drive: low bytes with the request F, then high bytes chained on the low-pass F.
    // Z16 only on the high pass of ADC/SBC so Z reflects both bytes being zero.
    always_comb begin
        alu_op      = ALU_ADD;
        alu_busa    = 8'd0;
        alu_busb    = 8'd0;
        alu_f_in    = 8'd0;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        case (state_q)
            ST_LO: begin
                alu_op      = add16 ? ALU_ADD : ((op_q == OP_SBC16) ? ALU_SBC : ALU_ADC);
                alu_busa    = a_q[7:0];
                alu_busb    = b_q[7:0];
                alu_f_in    = f_q;
                alu_arith16 = add16;
            end
            ST_HI: begin
                alu_op      = (op_q == OP_SBC16) ? ALU_SBC : ALU_ADC;
                alu_busa    = a_q[15:8];
                alu_busb    = b_q[15:8];
                alu_f_in    = f_lo_q;
                alu_arith16 = add16;
                alu_z16     = !add16;
            end
            default: ;
        endcase
    end

    // State, request capture, per-pass result capture and response hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            f_q         <= 8'd0;
            res_lo_q    <= 8'd0;
            f_lo_q      <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= 16'd0;
            rsp_f_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
                f_q  <= req_f;
            end
            if (state_q == ST_LO) begin
                res_lo_q <= alu_q;
                f_lo_q   <= alu_f_out;
            end
            if (state_q == ST_HI) begin
                rsp_res_q   <= {alu_q, res_lo_q};
                rsp_f_q     <= alu_f_out;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == ST_DONE) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule
